// File: rtl/cofre_fsm.sv
// ============================================================================
// cofre_fsm -- sequential bank-vault door controller
//
// A card-holder keeps the card inserted (cartao) and keys a NDIGITS-digit code
// one digit at a time on `digito`, confirming each digit with a rising edge of
// `confirma`. A full code is compared against SENHA:
//   - match    : the door opens for OPEN_CYCLES clocks and the attempt count
//                is cleared;
//   - mismatch : the attempt count grows. Reaching MAX_TENT forces a lockout
//                of LOCK_CYCLES clocks with the alarm on.
//
// Optional build macro:
//   COFRE_ALARM_LATCH_EN : when defined, `alarme` latches high once a lockout
//                          starts and only reset_n clears it. When undefined,
//                          `alarme` follows the LOCKOUT state.
//
// Ports:
//   clk_2        in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   cartao       in   card present (must stay high during entry)
//   confirma     in   level switch, each rising edge enters one digit
//   digito       in   current digit value [DIGIT_W]
//   porta_aberta out  door unlocked
//   bloqueado    out  lockout active
//   alarme       out  alarm LED
//   tentativas   out  failed attempts so far [$clog2(MAX_TENT+1)]
//   indice       out  digits captured in current attempt [$clog2(NDIGITS+1)]
//   estado       out  state code IDLE=0 ENTRY=1 CHECK=2 OPEN=3 LOCKOUT=4
//
// Every output comes straight from a register, so no input reaches an output
// without passing through a clock edge.
// ============================================================================
module cofre_fsm #(
    parameter int                         NDIGITS     = 4,
    parameter int                         DIGIT_W     = 4,
    parameter logic [NDIGITS*DIGIT_W-1:0] SENHA       = 16'h0000,
    parameter int                         MAX_TENT    = 3,
    parameter int                         OPEN_CYCLES = 5,
    parameter int                         LOCK_CYCLES = 10
) (
    input  logic                            clk_2,
    input  logic                            reset_n,
    input  logic                            cartao,
    input  logic                            confirma,
    input  logic [DIGIT_W-1:0]              digito,
    output logic                            porta_aberta,
    output logic                            bloqueado,
    output logic                            alarme,
    output logic [$clog2(MAX_TENT+1)-1:0]   tentativas,
    output logic [$clog2(NDIGITS+1)-1:0]    indice,
    output logic [2:0]                      estado
);

    localparam int NB   = NDIGITS * DIGIT_W;
    localparam int TW   = $clog2(MAX_TENT + 1);
    localparam int IW   = $clog2(NDIGITS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMW  = $clog2(TMAX + 1);

    localparam logic [IW-1:0]  IDX_LAST  = IW'(NDIGITS - 1);
    localparam logic [TW-1:0]  TENT_MAX  = TW'(MAX_TENT);
    localparam logic [TW-1:0]  TENT_LAST = TW'(MAX_TENT - 1);
    localparam logic [TMW-1:0] OPEN_LAST = TMW'(OPEN_CYCLES - 1);
    localparam logic [TMW-1:0] LOCK_LAST = TMW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t          state_r;
    logic            confirma_q_r;
    logic [NB-1:0]   code_buf_r;
    logic [IW-1:0]   indice_r;
    logic [TW-1:0]   tent_r;
    logic [TMW-1:0]  timer_r;
    logic            porta_aberta_r;
    logic            bloqueado_r;
    logic            alarme_r;
    logic            conf_ev_s;
    logic            alarme_hold_s;

    // Rising-edge detect of the confirm switch. confirma_q resets low, so a
    // switch held high through reset produces one event on the first edge;
    // that edge always lands in IDLE, where events are ignored.
    assign conf_ev_s = confirma & ~confirma_q_r;

`ifdef COFRE_ALARM_LATCH_EN
    // Latched alarm: once set it holds until reset_n.
    assign alarme_hold_s = alarme_r;
`else
    // Alarm follows the lockout state only.
    assign alarme_hold_s = 1'b0;
`endif

    // Confirm-switch history register for the edge detector.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            confirma_q_r <= 1'b0;
        end else begin
            confirma_q_r <= confirma;
        end
    end

    // Main controller FSM. It updates state, counters and registered outputs.
    // Output registers default to their idle value each cycle. Transitions
    // into or within OPEN/LOCKOUT override those defaults, so the outputs line
    // up with the state register.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            code_buf_r     <= '0;
            indice_r       <= '0;
            tent_r         <= '0;
            timer_r        <= '0;
            porta_aberta_r <= 1'b0;
            bloqueado_r    <= 1'b0;
            alarme_r       <= 1'b0;
        end else begin
            porta_aberta_r <= 1'b0;
            bloqueado_r    <= 1'b0;
            alarme_r       <= alarme_hold_s;
            case (state_r)
                ST_IDLE: begin
                    timer_r <= '0;
                    if (cartao) begin
                        state_r    <= ST_ENTRY;
                        indice_r   <= '0;
                        code_buf_r <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ENTRY: begin
                    // Card removal wins over a digit confirmed in the same cycle.
                    if (!cartao) begin
                        state_r  <= ST_IDLE;
                        indice_r <= '0;
                    end else if (conf_ev_s) begin
                        // Shifting left puts the first digit in the MSB slot.
                        code_buf_r <= (code_buf_r << DIGIT_W) | NB'(digito);
                        indice_r   <= indice_r + IW'(1);
                        if (indice_r == IDX_LAST) begin
                            state_r <= ST_CHECK;
                        end else begin
                            state_r <= ST_ENTRY;
                        end
                    end else begin
                        state_r <= ST_ENTRY;
                    end
                end
                ST_CHECK: begin
                    timer_r <= '0;
                    if (code_buf_r == SENHA) begin
                        tent_r         <= '0;
                        state_r        <= ST_OPEN;
                        porta_aberta_r <= 1'b1;
                    end else if (tent_r >= TENT_LAST) begin
                        // The attempt count saturates at MAX_TENT.
                        tent_r      <= TENT_MAX;
                        state_r     <= ST_LOCKOUT;
                        bloqueado_r <= 1'b1;
                        alarme_r    <= 1'b1;
                    end else begin
                        tent_r     <= tent_r + TW'(1);
                        state_r    <= ST_ENTRY;
                        indice_r   <= '0;
                        code_buf_r <= '0;
                    end
                end
                ST_OPEN: begin
                    if (timer_r == OPEN_LAST) begin
                        timer_r <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        timer_r        <= timer_r + TMW'(1);
                        state_r        <= ST_OPEN;
                        porta_aberta_r <= 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_r == LOCK_LAST) begin
                        timer_r <= '0;
                        tent_r  <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        timer_r     <= timer_r + TMW'(1);
                        state_r     <= ST_LOCKOUT;
                        bloqueado_r <= 1'b1;
                        alarme_r    <= 1'b1;
                    end
                end
                default: begin
                    // Unused codes 5..7 recover to IDLE.
                    state_r  <= ST_IDLE;
                    timer_r  <= '0;
                    indice_r <= '0;
                end
            endcase
        end
    end

    assign porta_aberta = porta_aberta_r;
    assign bloqueado    = bloqueado_r;
    assign alarme       = alarme_r;
    assign tentativas   = tent_r;
    assign indice       = indice_r;
    assign estado       = state_r;

endmodule
